image_ram_writer: RTL and testbench
===================================

IMAGE_RAM_WRITER -- requirements
Module: image_ram_writer

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 256, image width in pixels.
REQ-002 The block SHALL have parameter IMG_HEIGHT, default 256, image height in pixels; IMG_WIDTH*IMG_HEIGHT SHALL be at most 65536.
REQ-003 The block SHALL have parameter CLEAR_VALUE, default 255, pixel value written during clear.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port start  input  1  one-cycle request to load one frame.
REQ-007 The block SHALL have port clear  input  1  one-cycle request to fill the RAM with CLEAR_VALUE.
REQ-008 The block SHALL have port pix_valid  input  1  incoming pixel beat valid.
REQ-009 The block SHALL have port pix_data  input  8  incoming grayscale pixel.
REQ-010 The block SHALL have port pix_ready  output  1  block accepts a pixel this cycle.
REQ-011 The block SHALL have port address  output  16  RAM write address.
REQ-012 The block SHALL have port data  output  32  RAM write data, {24'd0, pixel}.
REQ-013 The block SHALL have port wren  output  1  RAM write enable.
REQ-014 The block SHALL have port busy  output  1  high in LOAD or CLEAR.
REQ-015 The block SHALL have port done  output  1  one-cycle pulse at end of load or clear.
REQ-016 The block SHALL have port frame_error  output  1  sticky flag: pix_valid seen while not loading.

Function
REQ-017 The block SHALL implement states IDLE, LOAD, CLEAR, DONE.
REQ-018 In IDLE, clear=1 SHALL go to CLEAR; clear=0 with start=1 SHALL go to LOAD; clear wins when both are high.
REQ-019 start and clear SHALL be ignored in LOAD, CLEAR and DONE.
REQ-020 On entry to LOAD or CLEAR, the pixel counters x and y SHALL be 0.
REQ-021 pix_ready SHALL equal 1 exactly when state is LOAD; a beat is accepted when pix_valid and pix_ready are both 1.
REQ-022 For a beat accepted in cycle N, the block SHALL present, registered in cycle N+1: wren=1, address=x+IMG_WIDTH*y (16-bit), data={24'd0,pix_data}. One write per accepted beat, pixels in raster order.
REQ-023 In any cycle without an accepted beat and outside CLEAR, wren SHALL be 0.
REQ-024 After each write, x SHALL increment; at x=IMG_WIDTH-1, x SHALL wrap to 0 and y SHALL increment.
REQ-025 After the write with x=IMG_WIDTH-1 and y=IMG_HEIGHT-1 is issued, the state SHALL go to DONE; no further beats are accepted.
REQ-026 In CLEAR, the block SHALL write CLEAR_VALUE every cycle with wren=1, address 0 through IMG_WIDTH*IMG_HEIGHT-1 ascending, then go to DONE.
REQ-027 DONE SHALL last one cycle with done=1 and then return to IDLE; done SHALL be 0 in all other states.
REQ-028 busy SHALL be 1 exactly in LOAD and CLEAR.
REQ-029 pix_valid=1 in any state other than LOAD SHALL set frame_error; frame_error SHALL clear only on reset or on an accepted start/clear.
REQ-030 Stalls (pix_valid=0 in LOAD) SHALL hold x, y and state without limit.

Reset
REQ-031 reset=0 SHALL asynchronously force: state IDLE, x=0, y=0, address=0, data=0, wren=0, pix_ready=0, busy=0, done=0, frame_error=0.
REQ-032 Reset asserted mid-LOAD or mid-CLEAR SHALL abort the operation with no further writes; the block SHALL restart only on a new start or clear after reset release.

Verification
REQ-033 With IMG_WIDTH=4 and IMG_HEIGHT=2: start, then 8 back-to-back beats 0x10..0x17 -> writes at addresses 0..7 with data 0x10..0x17, each one cycle after acceptance; done pulses once; pix_ready drops after the 8th beat.
REQ-034 Same parameters, beats with pix_valid gaps of 0-3 cycles -> identical address/data sequence, no write in gap cycles, x wraps 3->0 as y goes 0->1 (address 4).
REQ-035 clear and start asserted together in IDLE -> 8 consecutive writes of 0x000000FF to addresses 0..7, busy=1 for 8 cycles, then done; start ignored.
REQ-036 pix_valid=1 while IDLE -> frame_error=1 and stays 1 through DONE; the next start clears it.
REQ-037 reset=0 asserted after the 3rd accepted beat -> all outputs 0 immediately; after release, a new start writes from address 0.

Source files
------------

// File: rtl/image_ram_writer.sv
// image_ram_writer: streams one grayscale frame (or a constant fill) into a
// 32-bit-wide RAM, one pixel per word, in raster order.
module image_ram_writer #(
    parameter int unsigned IMG_WIDTH   = 256,
    parameter int unsigned IMG_HEIGHT  = 256,
    parameter logic [7:0]  CLEAR_VALUE = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        clear,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic        pix_ready,
    output logic [15:0] address,
    output logic [31:0] data,
    output logic        wren,
    output logic        busy,
    output logic        done,
    output logic        frame_error
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StClear = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [15:0] LastX = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] LastY = 16'(IMG_HEIGHT - 1);
    localparam logic [15:0] Width = 16'(IMG_WIDTH);

    state_e      r_state;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_address;
    logic [31:0] r_data;
    logic        r_wren;
    logic        r_frame_error;

    logic [15:0] w_addr;
    logic        w_last_x;
    logic        w_last_pix;
    logic        w_accept;

    // Raster address of the current (x, y) position and end-of-line/frame flags
    always_comb begin
        w_addr     = r_x + Width * r_y;
        w_last_x   = (r_x == LastX);
        w_last_pix = w_last_x && (r_y == LastY);
        w_accept   = (r_state == StLoad) && pix_valid;
    end

    // Control FSM, pixel counters and registered RAM write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= StIdle;
            r_x           <= 16'd0;
            r_y           <= 16'd0;
            r_address     <= 16'd0;
            r_data        <= 32'd0;
            r_wren        <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_wren <= 1'b0;
            // A stray beat outside LOAD is always a protocol error
            if (pix_valid && (r_state != StLoad)) begin
                r_frame_error <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (clear || start) begin
                        r_state       <= clear ? StClear : StLoad;
                        r_x           <= 16'd0;
                        r_y           <= 16'd0;
                        // Accepted request clears the flag unless a stray beat
                        // arrives in the very same cycle
                        r_frame_error <= pix_valid;
                    end
                end
                StLoad, StClear: begin
                    if (w_accept || (r_state == StClear)) begin
                        r_wren    <= 1'b1;
                        r_address <= w_addr;
                        r_data    <= {24'd0, (r_state == StClear) ? CLEAR_VALUE : pix_data};
                        if (w_last_pix) begin
                            r_state <= StDone;
                            r_x     <= 16'd0;
                            r_y     <= 16'd0;
                        end else if (w_last_x) begin
                            r_x <= 16'd0;
                            r_y <= r_y + 16'd1;
                        end else begin
                            r_x <= r_x + 16'd1;
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Status outputs are pure decodes of the registered state
    always_comb begin
        pix_ready   = (r_state == StLoad);
        busy        = (r_state == StLoad) || (r_state == StClear);
        done        = (r_state == StDone);
        address     = r_address;
        data        = r_data;
        wren        = r_wren;
        frame_error = r_frame_error;
    end

endmodule

// File: tb/tb_image_ram_writer.sv
// Directed bench for image_ram_writer with a 4x2 image.
module tb_image_ram_writer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        clear;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic [15:0] address;
    logic [31:0] data;
    logic        wren;
    logic        busy;
    logic        done;
    logic        frame_error;

    int checks   = 0;
    int failures = 0;

    image_ram_writer #(
        .IMG_WIDTH   (4),
        .IMG_HEIGHT  (2),
        .CLEAR_VALUE (8'hFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .clear       (clear),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .address     (address),
        .data        (data),
        .wren        (wren),
        .busy        (busy),
        .done        (done),
        .frame_error (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling and driving happen 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, 32'(address), 32'h0);
        chk({tag, "_data"}, data, 32'h0);
        chk({tag, "_wren"}, 32'(wren), 32'h0);
        chk({tag, "_ready"}, 32'(pix_ready), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_ferr"}, 32'(frame_error), 32'h0);
    endtask

    int gaps [8] = '{0, 2, 1, 3, 0, 1, 2, 3};

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        clear     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        #2;
        chk_all_zero("reset");
        step();
        step();
        reset = 1'b1;
        step();
        chk("idle_ready", 32'(pix_ready), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);

        // Back-to-back frame 0x10..0x17
        start = 1'b1;
        step();
        start = 1'b0;
        chk("load_ready", 32'(pix_ready), 32'h1);
        chk("load_busy", 32'(busy), 32'h1);
        chk("load_wren0", 32'(wren), 32'h0);
        for (int i = 0; i < 8; i++) begin
            pix_valid = 1'b1;
            pix_data  = 8'(8'h10 + i);
            step();
            chk("b2b_wren", 32'(wren), 32'h1);
            chk("b2b_addr", 32'(address), 32'(i));
            chk("b2b_data", data, 32'(8'h10 + i));
            chk("b2b_done", 32'(done), (i == 7) ? 32'h1 : 32'h0);
            chk("b2b_ready", 32'(pix_ready), (i == 7) ? 32'h0 : 32'h1);
        end
        pix_valid = 1'b0;
        chk("b2b_end_busy", 32'(busy), 32'h0);
        step();
        chk("b2b_post_done", 32'(done), 32'h0);
        chk("b2b_post_wren", 32'(wren), 32'h0);
        chk("b2b_ferr", 32'(frame_error), 32'h0);

        // Same frame with stalls between beats
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                pix_valid = 1'b0;
                step();
                chk("gap_wren", 32'(wren), 32'h0);
                chk("gap_ready", 32'(pix_ready), 32'h1);
            end
            pix_valid = 1'b1;
            pix_data  = 8'(8'h10 + i);
            step();
            chk("gap_wr_wren", 32'(wren), 32'h1);
            chk("gap_wr_addr", 32'(address), 32'(i));
            chk("gap_wr_data", data, 32'(8'h10 + i));
        end
        pix_valid = 1'b0;
        chk("gap_done", 32'(done), 32'h1);
        step();
        chk("gap_idle_done", 32'(done), 32'h0);

        // Clear and start together: clear wins
        clear = 1'b1;
        start = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b0;
        chk("clr_busy0", 32'(busy), 32'h1);
        chk("clr_wren0", 32'(wren), 32'h0);
        chk("clr_ready", 32'(pix_ready), 32'h0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("clr_wren", 32'(wren), 32'h1);
            chk("clr_addr", 32'(address), 32'(k));
            chk("clr_data", data, 32'h0000_00FF);
            chk("clr_busy", 32'(busy), (k < 7) ? 32'h1 : 32'h0);
            chk("clr_done", 32'(done), (k == 7) ? 32'h1 : 32'h0);
        end
        step();
        chk("clr_after_busy", 32'(busy), 32'h0);
        chk("clr_after_ready", 32'(pix_ready), 32'h0);
        chk("clr_after_wren", 32'(wren), 32'h0);

        // Stray beat in IDLE sets the sticky error
        pix_valid = 1'b1;
        pix_data  = 8'hAA;
        step();
        pix_valid = 1'b0;
        chk("ferr_set", 32'(frame_error), 32'h1);
        chk("ferr_nowr", 32'(wren), 32'h0);
        step();
        step();
        chk("ferr_sticky", 32'(frame_error), 32'h1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ferr_cleared", 32'(frame_error), 32'h0);

        // Reset after third accepted beat aborts the load
        for (int i = 0; i < 3; i++) begin
            pix_valid = 1'b1;
            pix_data  = 8'(8'h20 + i);
            step();
        end
        chk("pre_rst_addr", 32'(address), 32'h2);
        chk("pre_rst_data", data, 32'h22);
        reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        step();
        chk("rst_hold_wren", 32'(wren), 32'h0);
        chk("rst_hold_ferr", 32'(frame_error), 32'h0);
        pix_valid = 1'b0;
        reset     = 1'b1;
        step();
        chk("post_rst_ready", 32'(pix_ready), 32'h0);
        chk("post_rst_wren", 32'(wren), 32'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pix_valid = 1'b1;
            pix_data  = 8'(8'h50 + i);
            step();
            chk("restart_addr", 32'(address), 32'(i));
            chk("restart_data", data, 32'(8'h50 + i));
        end
        pix_valid = 1'b0;
        chk("restart_done", 32'(done), 32'h1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
